// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and the rotating-priority search used by the 16-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] req_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // First set request scanning ptr, ptr+1, .. ptr+15; idx_t arithmetic supplies the mod-16 wrap.
    function automatic pick_t rr_pick(input req_t req, input idx_t ptr);
        pick_t res;
        idx_t  pos;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = ptr + idx_t'(i);
            if (!res.found && req[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb16_ctrl_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
interface rr_arb16_ctrl_if;
    import rr_arb_pkg::*;

    req_t req;
    logic done;
    idx_t gnt_idx;
    logic gnt_vld;
    req_t gnt_onehot;
    logic timeout;

    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_vld,
        input  gnt_onehot,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_vld,
        output gnt_onehot,
        output timeout
    );

endinterface

// File: rtl/bindec_4to16.sv
// 4-to-16 binary decoder with enable; bcode is all zeros when en is low.
module bindec_4to16 (
    input  logic [3:0]  acode,
    input  logic        en,
    output logic [15:0] bcode
);

    always_comb begin
        bcode = '0;
        if (en) begin
            bcode[acode] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb16_ctrl.sv
// Round-robin arbiter for 16 requesters with registered index/enable and decoded one-hot grant.
// Optional hold timer enabled by defining RR_ARB16_TIMEOUT_EN.
module rr_arb16_ctrl
    import rr_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arb16_ctrl_if.slave bus
);

    arb_state_t state_q, state_n;
    idx_t       ptr_q, ptr_n;
    idx_t       gnt_idx_q, gnt_idx_n;
    logic       gnt_vld_q, gnt_vld_n;
    logic       release_c;
    logic       timeout_c;
    idx_t       next_ptr;
    req_t       req_masked;
    pick_t      pick_idle;
    pick_t      pick_rel;
    req_t       onehot;

`ifdef RR_ARB16_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);

    logic [7:0] hold_cnt_q, hold_cnt_n;
`else
    // HOLD_MAX has no effect here; referenced so both builds share one parameter list.
    if (HOLD_MAX == 0) begin : g_hold_max_unused
    end
`endif

    // On release the holder is masked out and the search restarts just past it.
    always_comb begin
        next_ptr   = gnt_idx_q + idx_t'(1);
        req_masked = bus.req & ~(req_t'(1) << gnt_idx_q);
        pick_idle  = rr_pick(bus.req, ptr_q);
        pick_rel   = rr_pick(req_masked, next_ptr);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_n   = state_q;
        ptr_n     = ptr_q;
        gnt_idx_n = gnt_idx_q;
        gnt_vld_n = gnt_vld_q;
        release_c = 1'b0;
        timeout_c = 1'b0;
`ifdef RR_ARB16_TIMEOUT_EN
        hold_cnt_n = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_vld_n = pick_idle.found;
                if (pick_idle.found) begin
                    gnt_idx_n = pick_idle.idx;
                    state_n   = GRANT;
                end
            end
            GRANT: begin
`ifdef RR_ARB16_TIMEOUT_EN
                timeout_c = (hold_cnt_q == HOLD_LAST) && !bus.done && bus.req[gnt_idx_q];
`endif
                release_c = bus.done || !bus.req[gnt_idx_q] || timeout_c;
                if (release_c) begin
                    ptr_n = next_ptr;
`ifdef RR_ARB16_TIMEOUT_EN
                    hold_cnt_n = '0;
`endif
                    if (pick_rel.found) begin
                        gnt_idx_n = pick_rel.idx;
                    end else begin
                        gnt_vld_n = 1'b0;
                        state_n   = IDLE;
                    end
                end
`ifdef RR_ARB16_TIMEOUT_EN
                else begin
                    hold_cnt_n = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_n   = IDLE;
                gnt_vld_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
`ifdef RR_ARB16_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            gnt_idx_q <= gnt_idx_n;
            gnt_vld_q <= gnt_vld_n;
`ifdef RR_ARB16_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_n;
`endif
        end
    end

    bindec_4to16 u_dec (
        .acode (gnt_idx_q),
        .en    (gnt_vld_q),
        .bcode (onehot)
    );

    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.gnt_vld    = gnt_vld_q;
    assign bus.gnt_onehot = onehot;
    // Combinational so the pulse lines up with the cycle in which the timed-out grant is released.
    assign bus.timeout    = timeout_c;

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// Directed scoreboard bench for rr_arb16_ctrl; timeout rows switch on RR_ARB16_TIMEOUT_EN (HOLD_MAX=4).
module tb_rr_arb16_ctrl;
    import rr_arb_pkg::*;

    typedef struct packed {
        logic vld;
        idx_t idx;
        logic tmo;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    rr_arb16_ctrl_if bus ();

    rr_arb16_ctrl #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, wanted %0h at t=%0t", name, act, want, $time);
        end
    endtask

    // One cycle: inputs go in just after the edge, with the outputs expected for that same cycle.
    task automatic step(input req_t r, input logic d, input logic ev, input int ei, input logic et);
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.done = d;
        exp_q.push_back('{vld: ev, idx: idx_t'(ei), tmo: et});
    endtask

    always @(negedge clk) begin
        exp_t e;
        req_t oh;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            oh = e.vld ? (req_t'(1) << e.idx) : '0;
            check("gnt_vld", 32'(bus.gnt_vld), 32'(e.vld));
            if (e.vld) begin
                check("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
            end
            check("gnt_onehot", 32'(bus.gnt_onehot), 32'(oh));
            check("timeout", 32'(bus.timeout), 32'(e.tmo));
        end
    end

    always @(negedge clk) begin
        assert (bus.gnt_onehot == (bus.gnt_vld ? (req_t'(1) << bus.gnt_idx) : '0))
            else $error("onehot does not match index/valid");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int pre_idx;
        bus.req  = 16'hFFFF;
        bus.done = 1'b0;

        // Reset held with every request raised: all outputs stay clear.
        repeat (3) step(16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
        #2 rst_n = 1'b1;

        // Full rotation with done every cycle, including the 15 -> 0 wrap.
        for (int k = 0; k <= 15; k++) begin
            step(16'hFFFF, 1'b1, 1'b1, k, 1'b0);
        end
        step(16'h0000, 1'b1, 1'b1, 0, 1'b0);

        // ptr = 1 from IDLE: 15 wins before 0, then dropping req[15] hands off to 0.
        step(16'h8001, 1'b0, 1'b0, 0, 1'b0);
        step(16'h0001, 1'b0, 1'b1, 15, 1'b0);
        step(16'h0020, 1'b0, 1'b1, 0, 1'b0);

        // Lone requester 5: release, one IDLE cycle (done there is ignored), re-grant.
        step(16'h0020, 1'b1, 1'b1, 5, 1'b0);
        step(16'h0020, 1'b1, 1'b0, 0, 1'b0);
        step(16'h0009, 1'b0, 1'b1, 5, 1'b0);

        // Requesters 0 and 3, no done: hold timer decides.
`ifdef RR_ARB16_TIMEOUT_EN
        repeat (3) step(16'h0009, 1'b0, 1'b1, 0, 1'b0);
        step(16'h0009, 1'b0, 1'b1, 0, 1'b1);
        step(16'h0009, 1'b0, 1'b1, 3, 1'b0);
        pre_idx = 3;
`else
        repeat (5) step(16'h0009, 1'b0, 1'b1, 0, 1'b0);
        pre_idx = 0;
`endif

        // Reset dropped between edges while a grant is active.
        @(posedge clk);
        #1;
        check("pre_reset_vld", 32'(bus.gnt_vld), 32'd1);
        check("pre_reset_idx", 32'(bus.gnt_idx), 32'(pre_idx));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_vld", 32'(bus.gnt_vld), 32'd0);
        check("async_rst_onehot", 32'(bus.gnt_onehot), 32'd0);
        check("async_rst_timeout", 32'(bus.timeout), 32'd0);
        repeat (2) step(16'h8001, 1'b0, 1'b0, 0, 1'b0);
        #2 rst_n = 1'b1;

        // Search restarts at 0 after reset: 0 beats 15.
        step(16'h8001, 1'b1, 1'b1, 0, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 15, 1'b0);
        step(16'h0000, 1'b0, 1'b0, 0, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
